serial_adder_ctrl: RTL and testbench

//   Sequencer for a 1-bit serial full adder built from ^ | & ~ only.
//   - Accepts a WIDTH-bit operand pair over a valid/ready handshake.
//   - Feeds the operands LSB-first through the adder, one bit per cycle.
//   - Assembles the parallel sum and carry-out, then holds the result under

---
 rtl/serial_adder_ctrl.sv | 169 ++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - sequencer for a bit-serial full adder with valid/ready handshakes
//
// Purpose:
//   Accepts a WIDTH-bit operand pair, feeds it LSB-first through a 1-bit full
//   adder (one bit per clock), assembles the parallel sum and final carry, and
//   holds the result until the consumer takes it.
//
// Optional feature:
//   SERIAL_ADDER_CTRL_SUB_EN - when defined, 'sub' is sampled at accept and the
//   block computes a + ~b + 1 (carry_out=1 means no borrow). When undefined,
//   'sub' is ignored and the block always adds.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      operand pair valid
//   in_ready   out  1      controller can accept an operand pair (IDLE)
//   a, b       in   WIDTH  operands
//   sub        in   1      1 = subtract (only with SERIAL_ADDER_CTRL_SUB_EN)
//   out_valid  out  1      result valid (DONE)
//   out_ready  in   1      consumer takes the result
//   sum        out  WIDTH  result, modulo 2**WIDTH
//   carry_out  out  1      final carry of the serial chain

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_out_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             sub_eff;
    logic             sub_accept;
    logic             bit_b;
    logic             sum_bit;
    logic             carry_d;
    logic [WIDTH-1:0] acc_d;
    logic [CW-1:0]    cnt_d;

`ifdef SERIAL_ADDER_CTRL_SUB_EN
    logic sub_q;
    assign sub_eff    = sub_q;
    assign sub_accept = sub;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign sub_eff    = 1'b0;
    assign sub_accept = 1'b0;
`endif

    // Ripple incrementer built from xor/and so the block stays free of adders.
    function automatic logic [CW-1:0] incr(input logic [CW-1:0] x);
        logic [CW-1:0] r;
        logic          c;
        c = 1'b1;
        r = '0;
        for (int i = 0; i < CW; i++) begin
            r[i] = x[i] ^ c;
            c    = c & x[i];
        end
        return r;
    endfunction

    // Bit-serial full adder; subtraction inverts b and seeds the carry with 1.
    always_comb begin
        bit_b   = b_q[0] ^ sub_eff;
        sum_bit = a_q[0] ^ bit_b ^ carry_q;
        carry_d = (a_q[0] & bit_b) | (carry_q & (a_q[0] ^ bit_b));
        // New bit enters at the MSB so that after WIDTH shifts the LSB sits at bit 0.
        acc_d   = (acc_q >> 1) | (WIDTH'(sum_bit) << (WIDTH - 1));
        cnt_d   = incr(cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q        <= a;
                        b_q        <= b;
                        cnt_q      <= '0;
                        carry_q    <= sub_accept;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
`ifdef SERIAL_ADDER_CTRL_SUB_EN
                        sub_q      <= sub;
`endif
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_d;
                    // sum/carry_out only change when a complete result is ready.
                    if (cnt_q == LAST_BIT) begin
                        sum_q       <= acc_d;
                        carry_out_q <= carry_d;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    // in_ready stays low on the take edge, so no same-cycle accept.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = carry_out_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl at WIDTH 1, 8 and 16

module tb_serial_adder_ctrl;

`ifdef SERIAL_ADDER_CTRL_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid_v  [3];
    logic        in_ready_v  [3];
    logic [15:0] a_v         [3];
    logic [15:0] b_v         [3];
    logic        sub_v       [3];
    logic        out_valid_v [3];
    logic        out_ready_v [3];
    logic        carry_v     [3];
    logic [0:0]  sum1;
    logic [7:0]  sum8;
    logic [15:0] sum16;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]),
        .a(a_v[0][0:0]), .b(b_v[0][0:0]), .sub(sub_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
        .sum(sum1), .carry_out(carry_v[0])
    );

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]),
        .a(a_v[1][7:0]), .b(b_v[1][7:0]), .sub(sub_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
        .sum(sum8), .carry_out(carry_v[1])
    );

    serial_adder_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_v[2]), .in_ready(in_ready_v[2]),
        .a(a_v[2]), .b(b_v[2]), .sub(sub_v[2]),
        .out_valid(out_valid_v[2]), .out_ready(out_ready_v[2]),
        .sum(sum16), .carry_out(carry_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int width_of(input int idx);
        return (idx == 0) ? 1 : (idx == 1) ? 8 : 16;
    endfunction

    function automatic logic [15:0] sum_of(input int idx);
        return (idx == 0) ? {15'b0, sum1} : (idx == 1) ? {8'b0, sum8} : sum16;
    endfunction

    // Reference: plain integer arithmetic on the operand values.
    task automatic model(input int idx, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, output logic [15:0] es, output logic ec);
        int unsigned w, m, r;
        w = width_of(idx);
        m = (32'd1 << w) - 1;
        if (SUB_EN && sv) r = (av & m) + ((~bv) & m) + 1;
        else              r = (av & m) + (bv & m);
        es = 16'(r & m);
        ec = r[w];
    endtask

    // Drives one operation; returns the result, edges from accept to out_valid,
    // and holds out_ready low for 'hold' cycles before taking the result.
    task automatic run_op(input int idx, input logic [15:0] av, input logic [15:0] bv,
                          input logic sv, input int hold, input bit noise,
                          output logic [15:0] so, output logic co, output int lat);
        int guard;
        guard = 0;
        a_v[idx] = av; b_v[idx] = bv; sub_v[idx] = sv;
        in_valid_v[idx] = 1'b1;
        while (in_ready_v[idx] !== 1'b1 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        in_valid_v[idx] = 1'b0;
        lat = 0;
        do begin
            if (noise) begin
                in_valid_v[idx] = 1'($urandom_range(0, 1));
                a_v[idx] = 16'($urandom);
                b_v[idx] = 16'($urandom);
            end
            @(negedge clk);
            lat++;
        end while (out_valid_v[idx] !== 1'b1 && lat < 64);
        in_valid_v[idx] = 1'b0;
        repeat (hold) @(negedge clk);
        so = sum_of(idx);
        co = carry_v[idx];
        out_ready_v[idx] = 1'b1;
        @(negedge clk);
        out_ready_v[idx] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 ||
                sum_of(i) !== 16'h0 || carry_v[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: in_ready=%b out_valid=%b sum=%h carry=%b, required 1 0 0 0",
                         i, in_ready_v[i], out_valid_v[i], sum_of(i), carry_v[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [15:0] s; logic c; int lat;
        run_op(1, 16'h5A, 16'h33, 1'b0, 0, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h8D || c !== 1'b0) begin
            errors++;
            $display("FAIL basic_5A_33: sum=%h carry=%b, required 8d 0", s, c);
        end
        checks++;
        if (lat !== 8) begin
            errors++;
            $display("FAIL basic_latency: %0d edges, required 8", lat);
        end
    endtask

    task automatic test_boundary();
        logic [15:0] s; logic c; int lat;
        run_op(1, 16'hFF, 16'h01, 1'b0, 1, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h00 || c !== 1'b1) begin
            errors++;
            $display("FAIL boundary_FF_01: sum=%h carry=%b, required 00 1", s, c);
        end
        run_op(1, 16'h00, 16'h00, 1'b0, 0, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h00 || c !== 1'b0) begin
            errors++;
            $display("FAIL boundary_00_00: sum=%h carry=%b, required 00 0", s, c);
        end
    endtask

    task automatic test_backpressure();
        int  guard;
        bit  bad;
        logic [15:0] es; logic ec;
        model(1, 16'hC4, 16'h5B, 1'b0, es, ec);
        a_v[1] = 16'hC4; b_v[1] = 16'h5B; sub_v[1] = 1'b0;
        in_valid_v[1] = 1'b1;
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        guard = 0;
        while (out_valid_v[1] !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            in_valid_v[1] = k[0];
            a_v[1] = 16'h11;
            b_v[1] = 16'h11;
            if (out_valid_v[1] !== 1'b1 || in_ready_v[1] !== 1'b0 ||
                sum8 !== es[7:0] || carry_v[1] !== ec) bad = 1'b1;
            @(negedge clk);
        end
        in_valid_v[1] = 1'b0;
        checks++;
        if (bad || out_valid_v[1] !== 1'b1 || sum8 !== es[7:0] || carry_v[1] !== ec) begin
            errors++;
            $display("FAIL backpressure_hold: out_valid=%b in_ready=%b sum=%h carry=%b, required 1 0 %h %b",
                     out_valid_v[1], in_ready_v[1], sum8, carry_v[1], es[7:0], ec);
        end
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        out_ready_v[1] = 1'b0;
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad || sum8 !== es[7:0]) begin
            errors++;
            $display("FAIL backpressure_no_accept: out_valid=%b in_ready=%b sum=%h, required 0 1 %h",
                     out_valid_v[1], in_ready_v[1], sum8, es[7:0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [15:0] s; logic c; int lat;
        bit bad;
        a_v[1] = 16'h5A; b_v[1] = 16'hC3; sub_v[1] = 1'b0;
        in_valid_v[1] = 1'b1;
        @(negedge clk);
        in_valid_v[1] = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (out_valid_v[1] !== 1'b0 || in_ready_v[1] !== 1'b1 || sum8 !== 8'h00 || carry_v[1] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: out_valid=%b in_ready=%b sum=%h carry=%b, required 0 1 00 0",
                     out_valid_v[1], in_ready_v[1], sum8, carry_v[1]);
        end
        bad = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (out_valid_v[1] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL reset_discard: out_valid=1, required 0 after reset mid-run");
        end
        run_op(1, 16'h0F, 16'h01, 1'b0, 0, 1'b0, s, c, lat);
        checks++;
        if (s !== 16'h10 || c !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_0F_01: sum=%h carry=%b, required 10 0", s, c);
        end
    endtask

    task automatic test_sub();
        logic [15:0] s; logic c; int lat;
        logic [15:0] es1, es2; logic ec1, ec2;
        es1 = SUB_EN ? 16'h0D : 16'h13; ec1 = SUB_EN ? 1'b1 : 1'b0;
        es2 = SUB_EN ? 16'hF3 : 16'h13; ec2 = 1'b0;
        run_op(1, 16'h10, 16'h03, 1'b1, 0, 1'b0, s, c, lat);
        checks++;
        if (s !== es1 || c !== ec1) begin
            errors++;
            $display("FAIL sub_10_03: sum=%h carry=%b, required %h %b", s, c, es1, ec1);
        end
        run_op(1, 16'h03, 16'h10, 1'b1, 0, 1'b0, s, c, lat);
        checks++;
        if (s !== es2 || c !== ec2) begin
            errors++;
            $display("FAIL sub_03_10: sum=%h carry=%b, required %h %b", s, c, es2, ec2);
        end
    endtask

    task automatic test_random(input int idx, input int n);
        logic [15:0] av, bv, s, es, m;
        logic sv, c, ec;
        int lat, w;
        w = width_of(idx);
        m = 16'((32'd1 << w) - 1);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            av = 16'($urandom) & m;
            bv = 16'($urandom) & m;
            sv = 1'($urandom_range(0, 1));
            model(idx, av, bv, sv, es, ec);
            run_op(idx, av, bv, sv, int'($urandom_range(0, 3)), 1'b1, s, c, lat);
            checks++;
            if (s !== es || c !== ec) begin
                errors++;
                $display("FAIL random_w%0d: a=%h b=%h sub=%b sum=%h carry=%b, required %h %b",
                         w, av, bv, sv, s, c, es, ec);
            end
            checks++;
            if (lat !== w) begin
                errors++;
                $display("FAIL random_latency_w%0d: %0d edges, required %0d", w, lat, w);
            end
            checks++;
            if (out_valid_v[idx] !== 1'b0 || in_ready_v[idx] !== 1'b1) begin
                errors++;
                $display("FAIL random_take_w%0d: out_valid=%b in_ready=%b, required 0 1",
                         w, out_valid_v[idx], in_ready_v[idx]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid_v[i]  = 1'b0;
            out_ready_v[i] = 1'b0;
            a_v[i] = '0; b_v[i] = '0; sub_v[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_boundary();
        test_backpressure();
        test_reset_mid_run();
        test_sub();
        test_random(0, 300);
        test_random(1, 400);
        test_random(2, 300);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
